// File: rtl/systolic_mm_ctrl_if.sv
// Operand/result handshake bundle between the register/DMA side and the systolic controller.
interface systolic_mm_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned MAT_W = 4 * DATA_WIDTH;

    logic             in_valid;
    logic             in_ready;
    logic [MAT_W-1:0] a_mat;
    logic [MAT_W-1:0] b_mat;
    logic             c_valid;
    logic             c_ready;
    logic [MAT_W-1:0] c_mat;

    modport master (
        output in_valid, a_mat, b_mat, c_ready,
        input  in_ready, c_valid, c_mat
    );

    modport slave (
        input  in_valid, a_mat, b_mat, c_ready,
        output in_ready, c_valid, c_mat
    );
endinterface

// File: rtl/systolic_mm_ctrl.sv
// Sequencer for a 2x2 systolic PE array: latches A/B, clears, skew-feeds, drains, and returns C.
module systolic_mm_ctrl #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    systolic_mm_ctrl_if.slave     bus,
    output logic                  busy,
    output logic                  sa_func_sel,
    output logic                  sa_clr,
    output logic [DATA_WIDTH-1:0] sa_data_11,
    output logic [DATA_WIDTH-1:0] sa_data_21,
    output logic [DATA_WIDTH-1:0] sa_tap_11,
    output logic [DATA_WIDTH-1:0] sa_tap_12,
    output logic [DATA_WIDTH-1:0] sa_fir_data_12,
    output logic [DATA_WIDTH-1:0] sa_fir_data_22,
    output logic [DATA_WIDTH-1:0] sa_fir_tap_21,
    output logic [DATA_WIDTH-1:0] sa_fir_tap_22,
    input  logic [DATA_WIDTH-1:0] sa_acc_11,
    input  logic [DATA_WIDTH-1:0] sa_acc_12,
    input  logic [DATA_WIDTH-1:0] sa_acc_21,
    input  logic [DATA_WIDTH-1:0] sa_acc_22
);
    localparam int unsigned DW    = DATA_WIDTH;
    localparam int unsigned MAT_W = 4 * DATA_WIDTH;
    localparam int unsigned KW    = 2;
    localparam int unsigned CW    = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [KW-1:0]     feed_k, feed_k_nxt;
    logic [CW-1:0]     drain_cnt, drain_cnt_nxt;
    logic [MAT_W-1:0]  a_q, a_nxt;
    logic [MAT_W-1:0]  b_q, b_nxt;
    logic [MAT_W-1:0]  c_q, c_nxt;
    logic              c_valid_q, c_valid_nxt;
    logic              in_ready_q, in_ready_nxt;
    logic              busy_q, busy_nxt;
    logic              clr_q, clr_nxt;
    logic [DW-1:0]     data_11_q, data_11_nxt;
    logic [DW-1:0]     data_21_q, data_21_nxt;
    logic [DW-1:0]     tap_11_q, tap_11_nxt;
    logic [DW-1:0]     tap_12_q, tap_12_nxt;

    logic [DW-1:0] a00, a01, a10, a11;
    logic [DW-1:0] b00, b01, b10, b11;

    assign a00 = a_q[DW-1:0];
    assign a01 = a_q[2*DW-1:DW];
    assign a10 = a_q[3*DW-1:2*DW];
    assign a11 = a_q[4*DW-1:3*DW];
    assign b00 = b_q[DW-1:0];
    assign b01 = b_q[2*DW-1:DW];
    assign b10 = b_q[3*DW-1:2*DW];
    assign b11 = b_q[4*DW-1:3*DW];

    // Next-state, counters, capture, and the registered edge-output values.
    always_comb begin
        state_nxt     = state;
        feed_k_nxt    = feed_k;
        drain_cnt_nxt = drain_cnt;
        a_nxt         = a_q;
        b_nxt         = b_q;
        c_nxt         = c_q;
        c_valid_nxt   = c_valid_q;
        data_11_nxt   = '0;
        data_21_nxt   = '0;
        tap_11_nxt    = '0;
        tap_12_nxt    = '0;

        case (state)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_nxt     = bus.a_mat;
                    b_nxt     = bus.b_mat;
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                feed_k_nxt = '0;
                state_nxt  = FEED;
            end
            FEED: begin
                if (feed_k == KW'(2)) begin
                    drain_cnt_nxt = '0;
                    state_nxt     = DRAIN;
                end else begin
                    feed_k_nxt = feed_k + KW'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt == CW'(DRAIN_CYCLES - 1)) begin
                    c_nxt       = {sa_acc_22, sa_acc_21, sa_acc_12, sa_acc_11};
                    c_valid_nxt = 1'b1;
                    state_nxt   = DONE;
                end else begin
                    drain_cnt_nxt = drain_cnt + CW'(1);
                end
            end
            DONE: begin
                if (bus.c_ready) begin
                    c_valid_nxt = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Diagonal skew: row 2 and column 2 lag row/column 1 by one cycle.
        if (state_nxt == FEED) begin
            case (feed_k_nxt)
                KW'(0): begin
                    data_11_nxt = a00;
                    tap_11_nxt  = b00;
                end
                KW'(1): begin
                    data_11_nxt = a01;
                    data_21_nxt = a10;
                    tap_11_nxt  = b10;
                    tap_12_nxt  = b01;
                end
                KW'(2): begin
                    data_21_nxt = a11;
                    tap_12_nxt  = b11;
                end
                default: ;
            endcase
        end

        in_ready_nxt = (state_nxt == IDLE);
        busy_nxt     = (state_nxt != IDLE);
        clr_nxt      = (state_nxt == CLEAR);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            feed_k     <= '0;
            drain_cnt  <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            c_valid_q  <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            clr_q      <= 1'b0;
            data_11_q  <= '0;
            data_21_q  <= '0;
            tap_11_q   <= '0;
            tap_12_q   <= '0;
        end else begin
            state      <= state_nxt;
            feed_k     <= feed_k_nxt;
            drain_cnt  <= drain_cnt_nxt;
            a_q        <= a_nxt;
            b_q        <= b_nxt;
            c_q        <= c_nxt;
            c_valid_q  <= c_valid_nxt;
            in_ready_q <= in_ready_nxt;
            busy_q     <= busy_nxt;
            clr_q      <= clr_nxt;
            data_11_q  <= data_11_nxt;
            data_21_q  <= data_21_nxt;
            tap_11_q   <= tap_11_nxt;
            tap_12_q   <= tap_12_nxt;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.c_valid  = c_valid_q;
    assign bus.c_mat    = c_q;
    assign busy         = busy_q;
    assign sa_clr       = clr_q;
    assign sa_data_11   = data_11_q;
    assign sa_data_21   = data_21_q;
    assign sa_tap_11    = tap_11_q;
    assign sa_tap_12    = tap_12_q;

    // The array is only ever used in matrix mode; FIR-side edges are tied off.
    assign sa_func_sel    = 1'b0;
    assign sa_fir_data_12 = '0;
    assign sa_fir_data_22 = '0;
    assign sa_fir_tap_21  = '0;
    assign sa_fir_tap_22  = '0;
endmodule

// File: tb/tb_systolic_mm_ctrl.sv
// Self-checking bench for systolic_mm_ctrl with a behavioural 2x2 systolic array attached.
module tb_systolic_mm_ctrl;
    localparam int unsigned DW    = 32;
    localparam int unsigned DC    = 4;
    localparam int unsigned MAT_W = 4 * DW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_mm_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    logic          busy, func_sel, clr;
    logic [DW-1:0] d11, d21, t11, t12, f12, f22, ft21, ft22;
    logic [DW-1:0] acc11, acc12, acc21, acc22;

    systolic_mm_ctrl #(.DATA_WIDTH(DW), .DRAIN_CYCLES(DC)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .busy           (busy),
        .sa_func_sel    (func_sel),
        .sa_clr         (clr),
        .sa_data_11     (d11),
        .sa_data_21     (d21),
        .sa_tap_11      (t11),
        .sa_tap_12      (t12),
        .sa_fir_data_12 (f12),
        .sa_fir_data_22 (f22),
        .sa_fir_tap_21  (ft21),
        .sa_fir_tap_22  (ft22),
        .sa_acc_11      (acc11),
        .sa_acc_12      (acc12),
        .sa_acc_21      (acc21),
        .sa_acc_22      (acc22)
    );

    // Behavioural array: a flows right, b flows down, each PE accumulates a*b.
    logic [DW-1:0] pa11, pb11, pa21, pb12;
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc11 <= '0; acc12 <= '0; acc21 <= '0; acc22 <= '0;
            pa11  <= '0; pb11  <= '0; pa21  <= '0; pb12  <= '0;
        end else begin
            acc11 <= acc11 + d11 * t11;
            acc12 <= acc12 + pa11 * t12;
            acc21 <= acc21 + d21 * pb11;
            acc22 <= acc22 + pa21 * pb12;
            pa11  <= d11;
            pb11  <= t11;
            pa21  <= d21;
            pb12  <= t12;
        end
    end

    int xfer_cnt = 0;
    always @(posedge clk) if (bus.c_valid && bus.c_ready) xfer_cnt <= xfer_cnt + 1;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [MAT_W-1:0] act, input logic [MAT_W-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    function automatic logic [MAT_W-1:0] mat(input logic [DW-1:0] e00, input logic [DW-1:0] e01,
                                             input logic [DW-1:0] e10, input logic [DW-1:0] e11);
        return {e11, e10, e01, e00};
    endfunction

    function automatic logic [MAT_W-1:0] edges();
        return {d11, d21, t11, t12};
    endfunction

    typedef struct {
        logic [MAT_W-1:0] a;
        logic [MAT_W-1:0] b;
        logic [MAT_W-1:0] c;
    } vec_t;

    vec_t vecs[4];
    logic [MAT_W-1:0] abas, bbas, cbas;

    task automatic wait_ready();
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("wait_in_ready", MAT_W'(bus.in_ready), MAT_W'(1));
    endtask

    // Returns with the accept edge just passed, sampled #1 after it.
    task automatic accept(input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b);
        wait_ready();
        bus.in_valid = 1'b1;
        bus.a_mat    = a;
        bus.b_mat    = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a_mat    = '1;
        bus.b_mat    = '1;
    endtask

    task automatic wait_c_valid(output int n, output logic ready_seen);
        n = 0;
        ready_seen = 1'b0;
        while (!bus.c_valid && n < 100) begin
            @(posedge clk); #1; n++;
            if (bus.in_ready) ready_seen = 1'b1;
        end
    endtask

    task automatic run_job(input string name, input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b,
                           input logic [MAT_W-1:0] c);
        int   n;
        logic seen;
        bus.c_ready = 1'b1;
        accept(a, b);
        check({name, "_busy_in_ready"}, MAT_W'({busy, bus.in_ready}), MAT_W'(2'b10));
        wait_c_valid(n, seen);
        // handshake edge = first edge at which c_valid is high
        check({name, "_latency"}, MAT_W'(n + 1), MAT_W'(5 + DC));
        check({name, "_c_mat"}, bus.c_mat, c);
        check({name, "_in_ready_low"}, MAT_W'(seen), MAT_W'(0));
        @(posedge clk); #1;
        check({name, "_post_handshake"}, MAT_W'({bus.c_valid, bus.in_ready, busy}), MAT_W'(3'b010));
    endtask

    initial begin
        logic [MAT_W-1:0] hold;
        logic [MAT_W-1:0] skew_exp[5];
        logic             ok, seen;
        int               n, x0;

        abas = mat(1, 2, 3, 4);
        bbas = mat(5, 6, 7, 8);
        cbas = mat(19, 22, 43, 50);
        vecs[0] = '{a: abas, b: bbas, c: cbas};
        vecs[1] = '{a: mat(1, 0, 0, 1), b: mat(9, 8, 7, 6), c: mat(9, 8, 7, 6)};
        vecs[2] = '{a: mat(32'h0001_0000, 0, 0, 0), b: mat(32'h0001_0000, 0, 0, 0), c: mat(0, 0, 0, 0)};
        vecs[3] = '{a: mat(32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFF), b: mat(2, 3, 4, 5),
                    c: mat(32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'hFFFF_FFFB)};

        bus.in_valid = 1'b0;
        bus.c_ready  = 1'b0;
        bus.a_mat    = '0;
        bus.b_mat    = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("reset_in_ready", MAT_W'(bus.in_ready), MAT_W'(1));
        check("reset_busy_cvalid_clr", MAT_W'({busy, bus.c_valid, clr}), MAT_W'(0));
        check("reset_c_mat", bus.c_mat, '0);
        check("reset_edges", edges(), '0);

        for (int i = 0; i < 4; i++) run_job($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c);

        // Backpressure: result held, extra in_valid while busy ignored, exactly one transfer.
        bus.c_ready = 1'b0;
        accept(abas, bbas);
        bus.in_valid = 1'b1;
        bus.a_mat    = mat(7, 7, 7, 7);
        bus.b_mat    = mat(7, 7, 7, 7);
        wait_c_valid(n, seen);
        check("bp_c_mat", bus.c_mat, cbas);
        hold = bus.c_mat;
        ok = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (!bus.c_valid || bus.c_mat !== hold || bus.in_ready) ok = 1'b0;
        end
        check("bp_hold", MAT_W'(ok), MAT_W'(1));
        bus.in_valid = 1'b0;
        x0 = xfer_cnt;
        bus.c_ready = 1'b1;
        @(posedge clk); #1;
        bus.c_ready = 1'b0;
        check("bp_release", MAT_W'({bus.c_valid, bus.in_ready}), MAT_W'(2'b01));
        repeat (3) @(posedge clk);
        #1;
        check("bp_one_transfer", MAT_W'(xfer_cnt - x0), MAT_W'(1));
        check("bp_c_mat_kept", bus.c_mat, cbas);

        // Reset during FEED k=1.
        bus.c_ready = 1'b1;
        accept(abas, bbas);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_pre_k1_edges", edges(), {32'd2, 32'd3, 32'd7, 32'd6});
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_in_ready_busy", MAT_W'({bus.in_ready, busy}), MAT_W'(2'b10));
        check("rst_mid_edges", edges(), '0);
        check("rst_mid_cvalid_clr", MAT_W'({bus.c_valid, clr}), MAT_W'(0));
        run_job("after_rst", abas, bbas, cbas);

        // Skew: edge outputs on each cycle after the accept edge.
        skew_exp[0] = '0;
        skew_exp[1] = {32'd1, 32'd0, 32'd5, 32'd0};
        skew_exp[2] = {32'd2, 32'd3, 32'd7, 32'd6};
        skew_exp[3] = {32'd0, 32'd4, 32'd0, 32'd8};
        skew_exp[4] = '0;
        bus.c_ready = 1'b1;
        accept(abas, bbas);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            check($sformatf("skew_edges_%0d", i), edges(), skew_exp[i]);
            check($sformatf("skew_clr_%0d", i), MAT_W'(clr), MAT_W'(i == 0));
            if (func_sel !== 1'b0 || {f12, f22, ft21, ft22} !== '0) ok = 1'b0;
        end
        wait_c_valid(n, seen);
        if (func_sel !== 1'b0 || {f12, f22, ft21, ft22} !== '0) ok = 1'b0;
        check("skew_tieoffs", MAT_W'(ok), MAT_W'(1));
        check("skew_c_mat", bus.c_mat, cbas);
        @(posedge clk); #1;
        check("skew_post", MAT_W'({bus.c_valid, bus.in_ready}), MAT_W'(2'b01));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/systolic_mm_ctrl.md
Name: systolic_mm_ctrl

Overview:
- Sequences the 2x2 systolic PE array for one 2x2 x 2x2 matrix multiply, C = A*B.
- Accepts A and B over a valid/ready handshake and clears the PE accumulators.
- Feeds operands to the array's edge inputs with the diagonal skew the array needs, then waits for the pipeline to drain.
- Captures the four accumulators and returns C over a valid/ready handshake.
- Sits between the user-project register/DMA logic and the array; holds the array in matrix mode (func_sel=0) at all times.

Parameters:
- DATA_WIDTH, 32, width of every matrix element, array operand and accumulator.
- DRAIN_CYCLES, 4, cycles waited after the last feed before the accumulators are sampled; legal range 1..15.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  A/B operands valid
- in_ready  output  1  controller can accept operands
- a_mat  input  4*DATA_WIDTH  A packed: [DW-1:0]=A00, [2DW-1:DW]=A01, [3DW-1:2DW]=A10, [4DW-1:3DW]=A11
- b_mat  input  4*DATA_WIDTH  B, same packing
- c_valid  output  1  result valid
- c_ready  input  1  consumer accepts result
- c_mat  output  4*DATA_WIDTH  C, same packing
- busy  output  1  high in any state other than IDLE
- sa_func_sel  output  1  array mode select; constant 0
- sa_clr  output  1  accumulator clear; integrator ORs this into the array reset
- sa_data_11, sa_data_21  output  DATA_WIDTH each  row-edge data into the array
- sa_tap_11, sa_tap_12  output  DATA_WIDTH each  column-edge taps into the array
- sa_fir_data_12, sa_fir_data_22, sa_fir_tap_21, sa_fir_tap_22  output  DATA_WIDTH each  constant 0
- sa_acc_11, sa_acc_12, sa_acc_21, sa_acc_22  input  DATA_WIDTH each  array accumulator outputs

Behaviour:
- Reset values:
  - State IDLE.
  - in_ready=1, busy=0, c_valid=0, c_mat=0, sa_clr=0.
  - All sa_data/sa_tap outputs 0.
  - Internal A/B registers 0; feed and drain counters 0.
- FSM states: IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready, latch a_mat and b_mat and go to CLEAR.
  - a_mat/b_mat are ignored in every other state.
- CLEAR:
  - One cycle with sa_clr=1 and all edge inputs 0; then FEED with counter k=0.
- FEED: three cycles, k=0,1,2. All edge outputs are registered.
  - k=0: data_11=A00, data_21=0, tap_11=B00, tap_12=0.
  - k=1: data_11=A01, data_21=A10, tap_11=B10, tap_12=B01.
  - k=2: data_11=0, data_21=A11, tap_11=0, tap_12=B11.
  - After k=2, go to DRAIN.
- DRAIN:
  - Edge outputs 0 for DRAIN_CYCLES cycles.
  - On the last DRAIN cycle's clock edge, register c_mat = {sa_acc_22, sa_acc_21, sa_acc_12, sa_acc_11}, set c_valid=1 and go to DONE.
- DONE:
  - c_valid=1; c_mat is held stable.
  - On c_valid & c_ready, clear c_valid and go to IDLE, where in_ready=1 on the next cycle.
  - No operand bypass: the minimum gap between accepts is 6+DRAIN_CYCLES cycles.
- Latency: a handshake accepted at edge T gives c_valid=1 at T+5+DRAIN_CYCLES, provided c_ready is already high.
- Arithmetic: the controller performs none. C elements are the array accumulators, taken verbatim (modulo 2^DATA_WIDTH).
- c_mat keeps its last value after c_valid drops, until the next capture.
- rst in any state, including mid-FEED or DONE:
  - Returns to IDLE next cycle with all outputs at reset values.
  - The pending result is discarded; c_valid drops without a handshake.
- c_ready high while in IDLE/CLEAR/FEED/DRAIN has no effect.
- in_valid high while busy has no effect; the operands are not queued.

Test Plan:
- A=[[1,2],[3,4]], B=[[5,6],[7,8]], c_ready=1 -> c_mat = C00=19, C01=22, C10=43, C11=50; c_valid rises exactly 9 cycles after the accept edge (DRAIN_CYCLES=4).
- Back-to-back: the previous job, then A=I, B=[[9,8],[7,6]] -> C=[[9,8],[7,6]]. This checks that CLEAR wipes the old accumulators; in_ready is low from the accept cycle until after the C handshake.
- Backpressure: c_ready=0 for 20 cycles after c_valid -> c_valid and c_mat held constant and in_ready=0 throughout; c_ready=1 gives exactly one transfer, then IDLE.
- Wrap (DW=32): A00=B00=0x00010000, other elements 0 -> C00=0x00000000; other elements 0.
- Reset mid-op: assert rst during FEED k=1 -> next cycle IDLE, in_ready=1, sa_* edge outputs 0, c_valid=0. A following job with A=[[1,2],[3,4]], B=[[5,6],[7,8]] returns [[19,22],[43,50]].
- Skew check: monitor the sa_* outputs with A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> sequence CLEAR (all 0, sa_clr=1), (1,0,5,0), (2,3,7,6), (0,4,0,8), then zeros; sa_func_sel and sa_fir_* are 0 throughout.
